// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
//   - register word offsets within the device (addr = PrAddr[3:2])
//   - MODE field encodings
//   - 2-bit FSM state encodings
//   - packed layout of the CTRL register
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'b00;
  localparam logic [1:0] TC_PRESET = 2'b01;
  localparam logic [1:0] TC_COUNT  = 2'b10;
  localparam logic [1:0] TC_RSVD   = 2'b11;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_CNT  = 2'b10;
  localparam logic [1:0] ST_INT  = 2'b11;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Reserved MODE values (1x) are kept in CTRL but run as one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD) && (mode != MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer, one instance per timer slot.
// Programmed with word writes; drives one HWInt bit and the PrRD read path.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset, clears all state
//   sel    device select from the bridge
//   addr   word offset within the device
//   we     write strobe, qualified by sel
//   wdata  write data
//   rdata  read data, combinational on addr (independent of sel)
//   irq    interrupt request = IM & pending
//
// FSM states:
//   state   | meaning
//   IDLE    | stopped, waits for EN=1
//   LOAD    | copies PRESET into COUNT
//   CNT     | decrements COUNT; EN=0 stops with COUNT held
//   INT     | terminal count reached, pending set; one-shot stops, reload restarts
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  ctrl_t            ctrl;
  logic [1:0]       state;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             pending;

  logic wr_ctrl;
  logic wr_preset;

  assign wr_ctrl   = sel & we & (addr == TC_CTRL);
  assign wr_preset = sel & we & (addr == TC_PRESET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl    <= '0;
      state   <= ST_IDLE;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_preset) preset <= wdata[CNT_W-1:0];

      case (state)
        ST_IDLE: if (ctrl.en) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.en) begin
            state <= ST_IDLE;
          end else if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            // COUNT of 0 or 1 both terminate here, so the counter never wraps.
            count   <= '0;
            pending <= 1'b1;
            state   <= ST_INT;
          end
        end
        default: begin
          if (is_reload(ctrl.mode)) begin
            pending <= 1'b0;
            state   <= ST_LOAD;
          end else begin
            ctrl.en <= 1'b0;
            state   <= ST_IDLE;
          end
        end
      endcase

      // Placed last so a CTRL write overrides the FSM's EN clear and pending set.
      if (wr_ctrl) begin
        ctrl    <= ctrl_t'(wdata[3:0]);
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      TC_CTRL:   rdata = {28'b0, ctrl};
      TC_PRESET: rdata = 32'(preset);
      TC_COUNT:  rdata = 32'(count);
      TC_RSVD:   rdata = '0;
      default:   rdata = '0;
    endcase
  end

  assign irq = ctrl.im & pending;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is "elapsed edges since the timer left idle". Edge j=0 is the
  // load, COUNT after edge j is PRESET for j=1 and K-(j-1) afterwards, where
  // K=max(PRESET,1); edge j=K+1 is terminal count, the edge after it ends or
  // restarts the run.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_pend;
  bit          m_run;
  longint      m_j;
  longint      m_k;
  logic [3:0]  n_ctrl;
  logic        n_pend;
  bit          w_ctrl;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 1'b0;
      m_run = 0; m_j = 0; m_k = 1;
    end else begin
      w_ctrl = sel && we && (addr == 2'd0);
      n_ctrl = m_ctrl;
      n_pend = m_pend;
      if (!m_run) begin
        if (m_ctrl[0]) begin m_run = 1; m_j = 0; end
      end else if (m_j == 0) begin
        m_count = m_preset;
        m_k = (m_preset == 0) ? 1 : longint'(m_preset);
        m_j = 1;
      end else if (m_j <= m_k) begin
        if (!m_ctrl[0]) m_run = 0;
        else begin
          m_j = m_j + 1;
          m_count = 32'(m_k - (m_j - 1));
          if (m_j == m_k + 1) n_pend = 1'b1;
        end
      end else begin
        if (m_ctrl[2:1] == 2'b01) begin
          n_pend = 1'b0;
          m_j = 0;
        end else begin
          n_ctrl[0] = 1'b0;
          m_run = 0;
        end
      end
      if (w_ctrl) begin n_ctrl = wdata[3:0]; n_pend = 1'b0; end
      if (sel && we && addr == 2'd1) m_preset = wdata;
      m_ctrl = n_ctrl;
      m_pend = n_pend;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    check("cyc_irq", {31'b0, irq}, {31'b0, m_ctrl[3] & m_pend});
    check("cyc_rdata", rdata, exp_rd(addr));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; addr = 2'd2; wdata = '0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a; #1;
    check(name, rdata, exp);
    addr = 2'd2;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd2; wdata = '0;
    #12;
    reset = 1'b0;
    step(1);
    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_preset", 2'd1, 32'h0);
    rd("rst_count", 2'd2, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // Asynchronous reset mid-count with COUNT=3.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(4);
    rd("mid_count3", 2'd2, 32'd3);
    reset = 1'b1;
    #1;
    check("arst_count", rdata, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    rd("arst_ctrl", 2'd0, 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    step(1);

    // One-shot with IM: irq exactly 7 edges after the CTRL write edge.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check("os_irq_edge", {31'b0, irq}, (i == 7) ? 32'h1 : 32'h0);
    end
    rd("os_count0", 2'd2, 32'h0);
    step(3);
    check("os_irq_hold", {31'b0, irq}, 32'h1);
    rd("os_ctrl_en_clr", 2'd0, 32'h8);
    wr(2'd0, 32'h8);
    check("os_irq_clr", {31'b0, irq}, 32'h0);
    step(2);

    // Auto-reload, PRESET=3: pulse every 5 edges, COUNT 3,2,1,0,(load),3.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      check("ar_irq", {31'b0, irq}, (i >= 5 && (i - 5) % 5 == 0) ? 32'h1 : 32'h0);
      if (i == 2) rd("ar_cnt3", 2'd2, 32'd3);
      if (i == 3) rd("ar_cnt2", 2'd2, 32'd2);
      if (i == 4) rd("ar_cnt1", 2'd2, 32'd1);
      if (i == 5) rd("ar_cnt0", 2'd2, 32'd0);
      if (i == 7) rd("ar_cnt3b", 2'd2, 32'd3);
    end
    wr(2'd0, 32'h0);
    step(3);

    // Disable while counting freezes COUNT.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    step(4);
    wr(2'd0, 32'h8);
    step(5);
    rd("frz_count", 2'd2, 32'd6);
    check("frz_irq", {31'b0, irq}, 32'h0);

    // CTRL write on the INT edge wins: EN kept, pending cleared.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step(2);
    wr(2'd0, 32'h9);
    rd("int_wr_ctrl", 2'd0, 32'h9);
    check("int_wr_irq", {31'b0, irq}, 32'h0);
    step(8);
    wr(2'd0, 32'h0);
    step(3);

    // PRESET=0 acts as 1; PRESET write during CNT; reserved mode runs one-shot.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(3);
    check("p0_irq_t3", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'd4);
    wr(2'd0, 32'hD);
    step(3);
    wr(2'd1, 32'd7);
    step(8);
    rd("rsv_ctrl", 2'd0, 32'hC);
    wr(2'd0, 32'h0);
    step(2);

    // IM=0 one-shot: pending is set but irq never rises.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    step(6);
    rd("im0_count", 2'd2, 32'd0);
    check("im0_irq", {31'b0, irq}, 32'h0);
    wr(2'd0, 32'h8);
    step(1);
    check("im0_irq_after", {31'b0, irq}, 32'h0);

    // Ignored writes: COUNT, offset 3, and unselected writes.
    wr(2'd2, 32'h1234);
    rd("ro_count", 2'd2, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd("rsvd_read", 2'd3, 32'd0);
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b1; addr = 2'd1; wdata = 32'hDEAD;
    @(posedge clk); #1;
    addr = 2'd0; wdata = 32'hF;
    @(posedge clk); #1;
    we = 1'b0; addr = 2'd2; wdata = '0;
    rd("nosel_preset", 2'd1, 32'd2);
    rd("nosel_ctrl", 2'd0, 32'h8);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
